// File: rtl/fp_exec_unit_iter.sv
// FP pipeline execute stage: forwarded operand select, single-cycle integer ALU and,
// when FP_SQRT_EN is defined, an iterative FSQRT.S engine that stalls upstream via halt.

module fp_exec_unit_iter #(
   parameter int XLEN                = 32,
   parameter int SQRT_BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic [3:0]      op,
   input  logic [1:0]      a_sel,
   input  logic            b_imm,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      fwd_rs1,
   input  logic [1:0]      fwd_rs2,
   input  logic [XLEN-1:0] fwd_mem,
   input  logic [XLEN-1:0] fwd_wb,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic            halt,
   output logic [4:0]      fflags
);
   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLT   = 4'd5;
   localparam logic [3:0] OP_SLTU  = 4'd6;
   localparam logic [3:0] OP_SLL   = 4'd7;
   localparam logic [3:0] OP_SRL   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_PASSB = 4'd10;
   localparam logic [3:0] OP_FSQRT = 4'd11;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic [XLEN-1:0] rs1_f, rs2_f, op_a, op_b, alu_res;

   always_comb begin
      rs1_f = fwd_rs1[1] ? fwd_mem : (fwd_rs1[0] ? fwd_wb : rs1_data);
      rs2_f = fwd_rs2[1] ? fwd_mem : (fwd_rs2[0] ? fwd_wb : rs2_data);
      case (a_sel)
         2'd0:    op_a = rs1_f;
         2'd1:    op_a = pc;
         default: op_a = '0;
      endcase
      op_b = b_imm ? imm : rs2_f;
   end

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:   alu_res = op_a + op_b;
         OP_SUB:   alu_res = op_a - op_b;
         OP_AND:   alu_res = op_a & op_b;
         OP_OR:    alu_res = op_a | op_b;
         OP_XOR:   alu_res = op_a ^ op_b;
         OP_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
         OP_SLTU:  alu_res = XLEN'(op_a < op_b);
         OP_SLL:   alu_res = op_a << op_b[SHW-1:0];
         OP_SRL:   alu_res = op_a >> op_b[SHW-1:0];
         OP_SRA:   alu_res = $signed(op_a) >>> op_b[SHW-1:0];
         OP_PASSB: alu_res = op_b;
         default:  alu_res = '0;
      endcase
   end

`ifdef FP_SQRT_EN
   localparam int K  = SQRT_BITS_PER_CYCLE;
   localparam int N  = (25 + K - 1) / K;
   localparam int RW = N * K;
   localparam int CW = $clog2(N);
   // Root bits beyond significand+guard only feed sticky
   localparam logic [RW-1:0] LOW_MASK = (RW'(1) << (RW - 25)) - RW'(1);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_ROUND, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [2*RW-1:0] rad_q, rad_n;
   logic [RW+2:0]   rem_q, rem_n, trial;
   logic [RW-1:0]   root_q, root_n;
   logic [7:0]      exp_q;
   logic            spec_q, spec_nv_q;
   logic [31:0]     spec_val_q;
   logic [31:0]     res_q;
   logic [4:0]      flg_q;
   logic            accept;

   logic [7:0]      fe;
   logic [22:0]     fm;
   logic            a_spec, a_nv;
   logic [31:0]     a_val;
   logic [2*RW-1:0] a_rad;
   logic [7:0]      a_exp;

   assign accept = valid_in && (op == OP_FSQRT) && (state_q == S_IDLE);

   // Special operands are resolved here and simply carried through the latency
   always_comb begin
      fe     = op_a[30:23];
      fm     = op_a[22:0];
      a_spec = 1'b1;
      a_nv   = 1'b0;
      a_val  = QNAN;
      if (fe == 8'hFF && fm != '0) a_nv = ~fm[22];
      else if (fe == 8'h00)         a_val = {op_a[31], 31'b0};
      else if (op_a[31])            a_nv = 1'b1;
      else if (fe == 8'hFF)         a_val = 32'h7F80_0000;
      else                          a_spec = 1'b0;
      // Odd biased exponent means even unbiased exponent: radicand stays 1.m
      a_rad = fe[0] ? ((2*RW)'({1'b1, fm}) << (2*RW - 25))
                    : ((2*RW)'({1'b1, fm}) << (2*RW - 24));
      a_exp = 8'((9'(fe) + 9'd126 + 9'(fe[0])) >> 1);
   end

   always_comb begin
      rem_n  = rem_q;
      root_n = root_q;
      rad_n  = rad_q;
      trial  = '0;
      for (int i = 0; i < K; i++) begin
         rem_n = {rem_n[RW:0], rad_n[2*RW-1 -: 2]};
         rad_n = rad_n << 2;
         trial = {1'b0, root_n, 2'b01};
         if (rem_n >= trial) begin
            rem_n  = rem_n - trial;
            root_n = {root_n[RW-2:0], 1'b1};
         end else begin
            root_n = {root_n[RW-2:0], 1'b0};
         end
      end
   end

   logic [23:0] sig;
   logic        grd, stk, inc, carry;
   logic [24:0] sum;
   logic [31:0] rnd_val;

   always_comb begin
      sig     = root_q[RW-1 -: 24];
      grd     = root_q[RW-25];
      stk     = (rem_q != '0) || ((root_q & LOW_MASK) != '0);
      inc     = grd & (stk | sig[0]);
      sum     = {1'b0, sig} + 25'(inc);
      carry   = sum[24];
      rnd_val = {1'b0, exp_q + 8'(carry), carry ? sum[23:1] : sum[22:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      halt         = 1'b0;
      result       = alu_res;
      result_valid = 1'b0;
      fflags       = 5'b0;
      case (state_q)
         S_IDLE: begin
            result_valid = valid_in && (op != OP_FSQRT);
            halt         = accept;
            if (accept) state_d = S_ITER;
         end
         S_ITER: begin
            halt = 1'b1;
            if (cnt_q == '0) state_d = S_ROUND;
         end
         S_ROUND: begin
            halt    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            result       = XLEN'(res_q);
            result_valid = 1'b1;
            fflags       = flg_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Held upstream inputs must not re-raise halt while reset is asserted
      if (reset) begin
         halt         = 1'b0;
         result_valid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         rad_q      <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         exp_q      <= '0;
         spec_q     <= 1'b0;
         spec_nv_q  <= 1'b0;
         spec_val_q <= '0;
         res_q      <= '0;
         flg_q      <= '0;
      end else if (accept) begin
         cnt_q      <= CW'(N - 1);
         rad_q      <= a_rad;
         rem_q      <= '0;
         root_q     <= '0;
         exp_q      <= a_exp;
         spec_q     <= a_spec;
         spec_nv_q  <= a_nv;
         spec_val_q <= a_val;
      end else if (state_q == S_ITER) begin
         rad_q  <= rad_n;
         rem_q  <= rem_n;
         root_q <= root_n;
         if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end else if (state_q == S_ROUND) begin
         res_q <= spec_q ? spec_val_q : rnd_val;
         flg_q <= spec_q ? {spec_nv_q, 4'b0} : {4'b0, grd | stk};
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ reset;

   always_comb begin
      halt         = 1'b0;
      result_valid = valid_in;
      result       = alu_res;
      fflags       = 5'b0;
      if (valid_in && op == OP_FSQRT) begin
         result = XLEN'(QNAN);
         fflags = 5'b10000;
      end
   end
`endif

endmodule
